smp_bus_arbiter: RTL and testbench
==================================

Name: smp_bus_arbiter

Overview:
Shared snoopy-bus arbiter and transaction sequencer for the SMP cache-coherency subsystem. It sits directly downstream of the per-CPU cache controllers and consumes their bus requests. It picks one master round-robin, broadcasts the address for snooping, and raises snoop_hit (the invalidate trigger) to the other sharers on writes. It sources read data from a dirty owner or from memory, then returns a one-cycle grant/completion to the master.

Parameters:
NUM_CPUS, 4, number of cache controllers (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req  in  NUM_CPUS  per-CPU bus request; held until that CPU's grant
req_rw  in  NUM_CPUS  per-CPU 1=write, 0=read
req_addr  in  NUM_CPUS*ADDR_W  per-CPU address, CPU i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_CPUS*DATA_W  per-CPU write data
snoop_match  in  NUM_CPUS  cache i holds bus_addr valid (SHARED/MODIFIED)
snoop_dirty  in  NUM_CPUS  cache i holds bus_addr MODIFIED
flush_data  in  NUM_CPUS*DATA_W  per-CPU dirty line data
grant  out  NUM_CPUS  one-hot completion pulse to the master
bus_valid  out  1  snoop broadcast valid
bus_addr  out  ADDR_W  broadcast address
bus_rw  out  1  broadcast direction
bus_rdata  out  DATA_W  read data, valid while grant high
snoop_hit  out  NUM_CPUS  one-cycle invalidate pulse to non-master sharers
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, single cycle
protocol_err  out  1  sticky error flag

Behaviour:
- All outputs registered. Reset clears every output to 0, sets state to IDLE, sets last_master to NUM_CPUS-1 and clears protocol_err. Reset mid-transaction aborts it: mem_req is low the cycle after reset, and no grant is issued.
- FSM states: IDLE, SNOOP, MEM, DONE.
- IDLE:
  - If req is nonzero, choose the first set bit searching from (last_master+1) mod NUM_CPUS upward, with wrap-around.
  - Latch master, addr, rw and wdata; go to SNOOP.
  - mem_ack seen in IDLE is ignored.
- SNOOP (exactly 1 cycle):
  - bus_valid=1 with the latched bus_addr/bus_rw. Sample snoop_match and snoop_dirty combinationally with the master's bit masked out.
  - Write, or read with no dirty owner: snoop_hit is asserted next cycle for 1 cycle, to all masked matching CPUs on a write and to none on a read.
  - Write: mem write of latched wdata.
  - Read with a dirty owner: take the lowest-index dirty CPU and capture its flush_data into bus_rdata. Write that data back to memory (mem_we=1); the requester gets flush data, not mem_rdata.
  - Read with no dirty owner: mem read.
  - More than one masked dirty bit sets protocol_err (sticky); the lowest index is still used.
  - Go to MEM.
- MEM:
  - mem_req=1 with mem_we/mem_addr/mem_wdata stable until mem_ack.
  - On mem_ack: mem_req drops next cycle. For a clean read, latch mem_rdata into bus_rdata. Go to DONE.
  - No timeout.
- DONE (1 cycle): grant[master]=1 with bus_rdata valid; last_master<=master; return to IDLE. A new request can be sampled in the IDLE cycle that follows.
- Latency: with req sampled in IDLE at cycle t and mem_ack on the first MEM cycle, SNOOP is t+1, MEM is t+2 and grant is at t+3. Each extra mem_ack wait cycle adds 1.
- Requests are sampled only in IDLE. A req deasserted mid-transaction does not cancel it; the grant still pulses. Requests arriving during a transaction wait.
- snoop_hit never targets the master. A write with no sharers produces snoop_hit=0.
- bus_valid is high only in SNOOP. grant is at most one-hot and high only in DONE.

Test Plan:
- Reset, then CPU1 read 0x100 with no sharers; memory acks 1 cycle later with 0xDEADBEEF -> mem_we=0, grant=4'b0010 at t+3, bus_rdata=0xDEADBEEF, snoop_hit=0.
- CPU0 write 0x200 data 0x5, snoop_match=4'b1011 -> snoop_hit=4'b1010 for one cycle, mem write 0x5 to 0x200, grant=4'b0001.
- CPU2 read 0x300 while CPU3 is dirty (snoop_dirty=4'b1000, flush_data[3]=0xCAFE), memory returns 0x0 -> bus_rdata=0xCAFE, mem write of 0xCAFE to 0x300, grant=4'b0100.
- req=4'b1111 held continuously, each transaction completed -> grants in order CPU0, CPU1, CPU2, CPU3, CPU0 (round-robin wrap).
- Hold mem_ack low 5 cycles -> mem_req stays high with stable address/data; grant comes 5 cycles later than baseline.
- snoop_dirty=4'b0110 on CPU0 read -> protocol_err=1 (stays 1), data from CPU1. Then assert reset during MEM -> all outputs 0 next cycle, no grant.

Source files
------------

// File: rtl/smp_bus_arbiter.sv
// Snoopy-bus arbiter and transaction sequencer for the SMP coherency subsystem.
// Round-robin master selection, snoop broadcast, dirty-owner intervention and memory sequencing.
module smp_bus_arbiter #(
    parameter int NUM_CPUS = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CPUS-1:0]          req,
    input  logic [NUM_CPUS-1:0]          req_rw,
    input  logic [NUM_CPUS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CPUS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_CPUS-1:0]          snoop_match,
    input  logic [NUM_CPUS-1:0]          snoop_dirty,
    input  logic [NUM_CPUS*DATA_W-1:0]   flush_data,
    output logic [NUM_CPUS-1:0]          grant,
    output logic                         bus_valid,
    output logic [ADDR_W-1:0]            bus_addr,
    output logic                         bus_rw,
    output logic [DATA_W-1:0]            bus_rdata,
    output logic [NUM_CPUS-1:0]          snoop_hit,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_ack,
    output logic                         protocol_err
);

    localparam int MW = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;

    typedef enum logic [1:0] {IDLE, SNOOP, MEM, DONE} state_t;

    state_t              state;
    logic [MW-1:0]       master;
    logic [MW-1:0]       last_master;
    logic [DATA_W-1:0]   wdata_lat;

    logic [MW-1:0]       cand_idx;
    logic [MW-1:0]       pick_idx;
    logic                pick_found;
    logic                pick_rw;
    logic [ADDR_W-1:0]   pick_addr;
    logic [DATA_W-1:0]   pick_wdata;

    logic [NUM_CPUS-1:0] master_mask;
    logic [NUM_CPUS-1:0] masked_match;
    logic [NUM_CPUS-1:0] masked_dirty;
    logic                has_dirty;
    logic                multi_dirty;
    logic [DATA_W-1:0]   flush_sel;

    // Round-robin pick: first requester at or after last_master+1, wrapping.
    always_comb begin
        cand_idx   = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            cand_idx = MW'((int'(last_master) + 1 + i) % NUM_CPUS);
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end else begin
                pick_found = pick_found;
            end
        end
    end

    // Mux the chosen master's request fields.
    always_comb begin
        pick_rw    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            if (MW'(i) == pick_idx) begin
                pick_rw    = req_rw[MW'(i)];
                pick_addr  = req_addr[i*ADDR_W +: ADDR_W];
                pick_wdata = req_wdata[i*DATA_W +: DATA_W];
            end else begin
                pick_rw = pick_rw;
            end
        end
    end

    // Snoop responses with the master's own bit removed; lowest-index dirty owner wins.
    always_comb begin
        master_mask  = ~(NUM_CPUS'(1) << master);
        masked_match = snoop_match & master_mask;
        masked_dirty = snoop_dirty & master_mask;
        has_dirty    = |masked_dirty;
        multi_dirty  = |(masked_dirty & (masked_dirty - NUM_CPUS'(1)));
        flush_sel    = '0;
        for (int i = NUM_CPUS - 1; i >= 0; i--) begin
            if (masked_dirty[MW'(i)]) begin
                flush_sel = flush_data[i*DATA_W +: DATA_W];
            end else begin
                flush_sel = flush_sel;
            end
        end
    end

    // Transaction FSM with all bus/memory outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            master       <= '0;
            last_master  <= MW'(NUM_CPUS - 1);
            wdata_lat    <= '0;
            grant        <= '0;
            bus_valid    <= 1'b0;
            bus_addr     <= '0;
            bus_rw       <= 1'b0;
            bus_rdata    <= '0;
            snoop_hit    <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    grant     <= '0;
                    snoop_hit <= '0;
                    if (|req) begin
                        master    <= pick_idx;
                        bus_addr  <= pick_addr;
                        bus_rw    <= pick_rw;
                        wdata_lat <= pick_wdata;
                        bus_valid <= 1'b1;
                        state     <= SNOOP;
                    end else begin
                        state <= IDLE;
                    end
                end
                SNOOP: begin
                    bus_valid <= 1'b0;
                    mem_req   <= 1'b1;
                    mem_addr  <= bus_addr;
                    if (bus_rw) begin
                        snoop_hit <= masked_match;
                        mem_we    <= 1'b1;
                        mem_wdata <= wdata_lat;
                        bus_rdata <= '0;
                    end else if (has_dirty) begin
                        // Dirty owner supplies the line and it is written back.
                        snoop_hit <= '0;
                        mem_we    <= 1'b1;
                        mem_wdata <= flush_sel;
                        bus_rdata <= flush_sel;
                    end else begin
                        snoop_hit <= '0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        bus_rdata <= '0;
                    end
                    if (multi_dirty) begin
                        protocol_err <= 1'b1;
                    end
                    state <= MEM;
                end
                MEM: begin
                    snoop_hit <= '0;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        // mem_we still holds the SNOOP decision here: clear read only.
                        if (!bus_rw && !mem_we) begin
                            bus_rdata <= mem_rdata;
                        end
                        grant <= NUM_CPUS'(1) << master;
                        state <= DONE;
                    end else begin
                        state <= MEM;
                    end
                end
                DONE: begin
                    grant       <= '0;
                    last_master <= master;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smp_bus_arbiter.sv
// Self-checking bench for smp_bus_arbiter: table of single-master transactions
// plus hand sequences for reset-in-MEM and round-robin wrap.
module tb_smp_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req;
    logic [N-1:0]      req_rw;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      snoop_match;
    logic [N-1:0]      snoop_dirty;
    logic [N*DW-1:0]   flush_data;
    logic [N-1:0]      grant;
    logic              bus_valid;
    logic [AW-1:0]     bus_addr;
    logic              bus_rw;
    logic [DW-1:0]     bus_rdata;
    logic [N-1:0]      snoop_hit;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ack;
    logic              protocol_err;

    smp_bus_arbiter #(.NUM_CPUS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .snoop_match(snoop_match), .snoop_dirty(snoop_dirty),
        .flush_data(flush_data), .grant(grant), .bus_valid(bus_valid), .bus_addr(bus_addr),
        .bus_rw(bus_rw), .bus_rdata(bus_rdata), .snoop_hit(snoop_hit), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           cpu;
        logic         rw;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [3:0]   match;
        logic [3:0]   dirty;
        logic [127:0] flush;
        logic [31:0]  mrdata;
        int           waits;
        logic [3:0]   exp_grant;
        logic [3:0]   exp_hit;
        logic         exp_we;
        logic [31:0]  exp_wdata;
        logic         chk_rdata;
        logic [31:0]  exp_rdata;
        logic         exp_err;
    } vec_t;

    vec_t        vecs[7];
    vec_t        sb[$];
    logic [3:0]  gsb[$];
    int          tests;
    int          fails;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   lat;
        lat = 0;
        req                      = 4'(1) << v.cpu;
        req_rw[v.cpu]            = v.rw;
        req_addr[v.cpu*AW +: AW] = v.addr;
        req_wdata[v.cpu*DW +: DW] = v.wdata;
        sb.push_back(v);
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_valid && lat < 10);
        check("snoop_latency", 64'(lat), 64'd1);
        check("bus_addr", 64'(bus_addr), 64'(v.addr));
        check("bus_rw", 64'(bus_rw), 64'(v.rw));
        snoop_match = v.match;
        snoop_dirty = v.dirty;
        flush_data  = v.flush;
        @(negedge clk);
        lat++;
        snoop_match = '0;
        snoop_dirty = '0;
        flush_data  = '0;
        check("snoop_hit", 64'(snoop_hit), 64'(v.exp_hit));
        check("bus_valid_off", 64'(bus_valid), 64'd0);
        check("mem_req_addr", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, v.addr});
        check("mem_we", 64'(mem_we), 64'(v.exp_we));
        if (v.exp_we) check("mem_wdata", 64'(mem_wdata), 64'(v.exp_wdata));
        check("protocol_err", 64'(protocol_err), 64'(v.exp_err));
        for (int w = 0; w < v.waits; w++) begin
            @(negedge clk);
            lat++;
            check("mem_hold", {mem_req, mem_we, mem_addr, 30'd0}, {1'b1, v.exp_we, v.addr, 30'd0});
        end
        mem_ack   = 1'b1;
        mem_rdata = v.mrdata;
        @(negedge clk);
        lat++;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        e = sb.pop_front();
        check("grant", 64'(grant), 64'(e.exp_grant));
        check("grant_latency", 64'(lat), 64'(3 + e.waits));
        check("mem_req_drop", 64'(mem_req), 64'd0);
        if (e.chk_rdata) check("bus_rdata", 64'(bus_rdata), 64'(e.exp_rdata));
        req = '0;
        @(negedge clk);
        check("grant_pulse", 64'(grant), 64'd0);
    endtask

    function automatic vec_t mk(int cpu, logic rw, logic [31:0] addr, logic [31:0] wdata,
                                logic [3:0] match, logic [3:0] dirty, logic [127:0] flush,
                                logic [31:0] mrdata, int waits, logic [3:0] eg, logic [3:0] eh,
                                logic ewe, logic [31:0] ewd, logic crd, logic [31:0] erd,
                                logic eerr);
        vec_t v;
        v.cpu = cpu; v.rw = rw; v.addr = addr; v.wdata = wdata; v.match = match;
        v.dirty = dirty; v.flush = flush; v.mrdata = mrdata; v.waits = waits;
        v.exp_grant = eg; v.exp_hit = eh; v.exp_we = ewe; v.exp_wdata = ewd;
        v.chk_rdata = crd; v.exp_rdata = erd; v.exp_err = eerr;
        return v;
    endfunction

    initial begin
        logic [127:0] fl_a;
        logic [127:0] fl_b;
        int           cnt;
        int           stray;
        tests = 0;
        fails = 0;
        fl_a = {32'h0000CAFE, 32'h22222222, 32'h11111111, 32'h00000000};
        fl_b = {32'hDDDD0003, 32'hBBBB0002, 32'hAAAA0001, 32'h99990000};
        //        cpu rw  addr          wdata        match  dirty  flush   mrdata        w  grant  hit    we  wdata         chk rdata         err
        vecs[0] = mk(1, 0, 32'h100, 32'h0,        4'b0000, 4'b0000, 128'd0, 32'hDEADBEEF, 0, 4'b0010, 4'b0000, 0, 32'h0,        1, 32'hDEADBEEF, 0);
        vecs[1] = mk(0, 1, 32'h200, 32'h5,        4'b1011, 4'b0000, 128'd0, 32'h12345678, 0, 4'b0001, 4'b1010, 1, 32'h5,        0, 32'h0,        0);
        vecs[2] = mk(2, 0, 32'h300, 32'h0,        4'b1000, 4'b1000, fl_a,   32'h0,        0, 4'b0100, 4'b0000, 1, 32'hCAFE,     1, 32'hCAFE,     0);
        vecs[3] = mk(3, 0, 32'h400, 32'h0,        4'b0000, 4'b0000, 128'd0, 32'h11112222, 5, 4'b1000, 4'b0000, 0, 32'h0,        1, 32'h11112222, 0);
        vecs[4] = mk(0, 0, 32'h500, 32'h0,        4'b0110, 4'b0110, fl_b,   32'h0,        0, 4'b0001, 4'b0000, 1, 32'hAAAA0001, 1, 32'hAAAA0001, 1);
        vecs[5] = mk(3, 1, 32'h600, 32'h77,       4'b1111, 4'b0000, 128'd0, 32'h0,        1, 4'b1000, 4'b0111, 1, 32'h77,       0, 32'h0,        1);
        vecs[6] = mk(1, 0, 32'h700, 32'h0,        4'b0010, 4'b0010, fl_b,   32'h55,       0, 4'b0010, 4'b0000, 0, 32'h0,        1, 32'h55,       1);

        reset = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        snoop_match = '0; snoop_dirty = '0; flush_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {grant, snoop_hit, bus_valid, bus_rw, mem_req, mem_we, protocol_err},
              64'd0);
        check("reset_data", {bus_addr, bus_rdata}, 64'd0);
        check("reset_mem", {mem_addr, mem_wdata}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Reset while waiting in MEM aborts the transaction.
        req = 4'b0100; req_rw[2] = 1'b0; req_addr[2*AW +: AW] = 32'h800;
        @(negedge clk);
        check("abort_snoop", 64'(bus_valid), 64'd1);
        @(negedge clk);
        check("abort_in_mem", 64'(mem_req), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_outputs", {grant, snoop_hit, bus_valid, mem_req, mem_we, protocol_err},
              64'd0);
        check("abort_data", {bus_addr, bus_rdata}, 64'd0);
        reset = 1'b0;
        req = '0;
        stray = 0;
        mem_ack = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (grant != '0 || mem_req) stray++;
        end
        mem_ack = 1'b0;
        check("abort_no_grant", 64'(stray), 64'd0);

        // Round-robin with every CPU requesting continuously.
        gsb.push_back(4'b0001); gsb.push_back(4'b0010); gsb.push_back(4'b0100);
        gsb.push_back(4'b1000); gsb.push_back(4'b0001);
        req_rw = '0;
        req = 4'b1111;
        mem_ack = 1'b1;
        for (int g = 0; g < 5; g++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (grant == '0 && cnt < 12);
            check("rr_grant", 64'(grant), 64'(gsb.pop_front()));
        end
        req = '0;
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
